// File: rtl/sm3_pkg.sv
// Purpose: shared SM3 constants, the A..H word-register bundle and the round helper functions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm3_pkg;

    // Word registers A..H carried between rounds; A is the most significant word.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } sm3_regs_t;

    // Initial hash value; also the reset image of the optional output register.
    localparam sm3_regs_t SM3_IV = '{
        a: 32'h7380166f,
        b: 32'h4914b2b9,
        c: 32'h172442d7,
        d: 32'hda8a0600,
        e: 32'ha96f30bc,
        f: 32'h163138aa,
        g: 32'he38dee4d,
        h: 32'hb0fb0e4e
    };

    // Round constants before the per-round rotation applied by the caller.
    localparam logic [31:0] T_LO = 32'h79cc4519;
    localparam logic [31:0] T_HI = 32'h7a879d8a;

    // 32-bit rotate left; n == 0 is handled because a 32-place right shift yields zero.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    // Permutation applied to TT2 before it becomes the new E.
    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction

    // Boolean function on A/B/C: parity in early rounds, majority afterwards.
    function automatic logic [31:0] ff(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic sm16);
        return sm16 ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
    endfunction

    // Boolean function on E/F/G: parity in early rounds, choose afterwards.
    function automatic logic [31:0] gg(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic sm16);
        return sm16 ? (x ^ y ^ z) : ((x & y) | (~x & z));
    endfunction

endpackage

// File: rtl/sm3_rnd_reg.sv
// Purpose: optional 8x32 output register with valid, loaded only on vld_i.
// Latency: 1 cycle from vld_i to vld_o; synchronous reset loads the IV.
// Backpressure: none; the register holds its words whenever vld_i is low.
module sm3_rnd_reg
    import sm3_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      vld_i,
    input  sm3_regs_t rnd_i,
    output logic      vld_o,
    output sm3_regs_t rnd_o
);

    sm3_regs_t rnd_q;
    sm3_regs_t rnd_d;
    logic      vld_q;
    logic      vld_d;

    // Next state: capture a new round result on vld_i, otherwise hold the words.
    always_comb begin
        rnd_d = rnd_q;
        vld_d = 1'b0;
        if (vld_i) begin
            rnd_d = rnd_i;
            vld_d = 1'b1;
        end
    end

    // State update; reset wins over a simultaneous vld_i and drops any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q <= SM3_IV;
            vld_q <= 1'b0;
        end else begin
            rnd_q <= rnd_d;
            vld_q <= vld_d;
        end
    end

    assign rnd_o = rnd_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/sm3_cmprss_ceil.sv
// Purpose: one SM3 compression round (A..H, Wj, W'j, pre-rotated Tj in; next A..H out).
// Latency: 0 cycles when REG_OUT=0, 1 cycle when REG_OUT=1.
// Backpressure: none; vld_i only qualifies data (and enables the register when present).
module sm3_cmprss_ceil
    import sm3_pkg::*;
#(
    parameter bit REG_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_i,
    output logic        vld_o,
    input  logic        cmprss_round_sm_16_i,
    input  logic [31:0] tj_i,
    input  logic [31:0] reg_a_i,
    input  logic [31:0] reg_b_i,
    input  logic [31:0] reg_c_i,
    input  logic [31:0] reg_d_i,
    input  logic [31:0] reg_e_i,
    input  logic [31:0] reg_f_i,
    input  logic [31:0] reg_g_i,
    input  logic [31:0] reg_h_i,
    input  logic [31:0] wj_i,
    input  logic [31:0] wjj_i,
    output logic [31:0] reg_a_o,
    output logic [31:0] reg_b_o,
    output logic [31:0] reg_c_o,
    output logic [31:0] reg_d_o,
    output logic [31:0] reg_e_o,
    output logic [31:0] reg_f_o,
    output logic [31:0] reg_g_o,
    output logic [31:0] reg_h_o
);

    logic [31:0] a_rot12;
    logic [31:0] ss1;
    logic [31:0] ss2;
    logic [31:0] tt1;
    logic [31:0] tt2;
    sm3_regs_t   rnd_d;
    sm3_regs_t   rnd_out;
    logic        vld_out;

    // Round datapath; the rotate -> 3-add -> xor -> 4-add chain here is the critical path.
    always_comb begin
        a_rot12 = rotl32(reg_a_i, 5'd12);
        ss1     = rotl32(a_rot12 + reg_e_i + tj_i, 5'd7);
        ss2     = ss1 ^ a_rot12;
        tt1     = ff(reg_a_i, reg_b_i, reg_c_i, cmprss_round_sm_16_i) + reg_d_i + ss2 + wjj_i;
        tt2     = gg(reg_e_i, reg_f_i, reg_g_i, cmprss_round_sm_16_i) + reg_h_i + ss1 + wj_i;
        rnd_d.a = tt1;
        rnd_d.b = reg_a_i;
        rnd_d.c = rotl32(reg_b_i, 5'd9);
        rnd_d.d = reg_c_i;
        rnd_d.e = p0(tt2);
        rnd_d.f = reg_e_i;
        rnd_d.g = rotl32(reg_f_i, 5'd19);
        rnd_d.h = reg_g_i;
    end

    generate
        if (REG_OUT) begin : g_reg
            sm3_rnd_reg u_rnd_reg (
                .clk   (clk),
                .rst   (rst),
                .vld_i (vld_i),
                .rnd_i (rnd_d),
                .vld_o (vld_out),
                .rnd_o (rnd_out)
            );
        end else begin : g_comb
            // clk/rst have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign vld_out        = vld_i;
            assign rnd_out        = rnd_d;
        end
    endgenerate

    assign vld_o   = vld_out;
    assign reg_a_o = rnd_out.a;
    assign reg_b_o = rnd_out.b;
    assign reg_c_o = rnd_out.c;
    assign reg_d_o = rnd_out.d;
    assign reg_e_o = rnd_out.e;
    assign reg_f_o = rnd_out.f;
    assign reg_g_o = rnd_out.g;
    assign reg_h_o = rnd_out.h;

endmodule

// File: tb/tb_sm3_cmprss_ceil.sv
// Purpose: self-checking bench for the SM3 round cell, combinational and registered builds.
// Latency: expects 0 cycles (REG_OUT=0) and 1 cycle (REG_OUT=1).
// Backpressure: n/a; expected results queue in a scoreboard and are popped at each output sample.
module tb_sm3_cmprss_ceil;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              vld0_i, vld1_i, vo0, vo1;
    logic              sm16;
    logic [31:0]       tj, wj, wjj;
    logic [7:0][31:0]  in_w;   // index 0 = A ... 7 = H
    logic [7:0][31:0]  o0_w, o1_w;

    typedef struct packed {
        logic [7:0][31:0] w;
        logic             vld;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [7:0][31:0] iv_w, abc_w, zero_w, fsel_w, wrap_w, dig_w, v_w;

    sm3_cmprss_ceil #(.REG_OUT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .vld_i(vld0_i), .vld_o(vo0),
        .cmprss_round_sm_16_i(sm16), .tj_i(tj),
        .reg_a_i(in_w[0]), .reg_b_i(in_w[1]), .reg_c_i(in_w[2]), .reg_d_i(in_w[3]),
        .reg_e_i(in_w[4]), .reg_f_i(in_w[5]), .reg_g_i(in_w[6]), .reg_h_i(in_w[7]),
        .wj_i(wj), .wjj_i(wjj),
        .reg_a_o(o0_w[0]), .reg_b_o(o0_w[1]), .reg_c_o(o0_w[2]), .reg_d_o(o0_w[3]),
        .reg_e_o(o0_w[4]), .reg_f_o(o0_w[5]), .reg_g_o(o0_w[6]), .reg_h_o(o0_w[7])
    );

    sm3_cmprss_ceil #(.REG_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .vld_i(vld1_i), .vld_o(vo1),
        .cmprss_round_sm_16_i(sm16), .tj_i(tj),
        .reg_a_i(in_w[0]), .reg_b_i(in_w[1]), .reg_c_i(in_w[2]), .reg_d_i(in_w[3]),
        .reg_e_i(in_w[4]), .reg_f_i(in_w[5]), .reg_g_i(in_w[6]), .reg_h_i(in_w[7]),
        .wj_i(wj), .wjj_i(wjj),
        .reg_a_o(o1_w[0]), .reg_b_o(o1_w[1]), .reg_c_o(o1_w[2]), .reg_d_o(o1_w[3]),
        .reg_e_o(o1_w[4]), .reg_f_o(o1_w[5]), .reg_g_o(o1_w[6]), .reg_h_o(o1_w[7])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x};
        return xx[63 - (n % 32) -: 32];
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    task automatic apply(input logic s, input logic [31:0] t, input logic [31:0] w,
                         input logic [31:0] ww, input logic [7:0][31:0] r);
        sm16 = s;
        tj   = t;
        wj   = w;
        wjj  = ww;
        in_w = r;
    endtask

    task automatic push_exp(input logic [7:0][31:0] w, input logic v);
        exp_t e;
        e.w   = w;
        e.vld = v;
        sb_q.push_back(e);
    endtask

    // Pops one expected entry and compares all eight words plus valid.
    task automatic check_out(input string tag, input logic [7:0][31:0] w, input logic v);
        exp_t e;
        chk({tag, "_sbdepth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 8; i++)
                chk($sformatf("%s_w%0d", tag, i), w[i], e.w[i]);
            chk({tag, "_vld"}, {31'd0, v}, {31'd0, e.vld});
        end
    endtask

    logic [31:0] wexp [68];

    initial begin
        iv_w  = {32'hb0fb0e4e, 32'he38dee4d, 32'h163138aa, 32'ha96f30bc,
                 32'hda8a0600, 32'h172442d7, 32'h4914b2b9, 32'h7380166f};
        abc_w = {32'he38dee4d, 32'hc550b189, 32'ha96f30bc, 32'hb2ad29f4,
                 32'h172442d7, 32'h29657292, 32'h7380166f, 32'hb9edc12b};
        zero_w = '0;
        fsel_w = '0; fsel_w[0] = 32'hffffffff; fsel_w[1] = 32'hffffffff;
        wrap_w = '0; wrap_w[3] = 32'hffffffff; wrap_w[7] = 32'hffffffff;
        dig_w = {32'h8f4ba8e0, 32'h297da02b, 32'h5cf2f7a2, 32'h4167c487,
                 32'hdc10e4e2, 32'hd1f2d46b, 32'h62eeedd9, 32'h66c7f0f4};

        rst = 1'b0; vld0_i = 1'b0; vld1_i = 1'b0;
        apply(1'b1, 32'h0, 32'h0, 32'h0, zero_w);
        #2;

        // Combinational build: the "abc" j=0 round.
        apply(1'b1, 32'h79cc4519, 32'h61626380, 32'h61626380, iv_w);
        vld0_i = 1'b1;
        push_exp(abc_w, 1'b1);
        #1 check_out("abc_j0", o0_w, vo0);

        // All-zero inputs with valid low.
        apply(1'b1, 32'h0, 32'h0, 32'h0, zero_w);
        vld0_i = 1'b0;
        push_exp(zero_w, 1'b0);
        #1 check_out("zeros", o0_w, vo0);

        // Function select, parity rounds then majority rounds.
        vld0_i = 1'b1;
        apply(1'b1, 32'h0, 32'h0, 32'h0, fsel_w);
        push_exp({32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h0, 32'hffffffff,
                  32'hffffffff, 32'h0}, 1'b1);
        #1 check_out("fsel_xor", o0_w, vo0);
        apply(1'b0, 32'h0, 32'h0, 32'h0, fsel_w);
        push_exp({32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h0, 32'hffffffff,
                  32'hffffffff, 32'hffffffff}, 1'b1);
        #1 check_out("fsel_maj", o0_w, vo0);

        // Modular wrap of TT1 and TT2.
        apply(1'b1, 32'h0, 32'h1, 32'h1, wrap_w);
        push_exp(zero_w, 1'b1);
        #1 check_out("wrap", o0_w, vo0);

        // 64-round "abc" compression through an external loop.
        for (int j = 0; j < 16; j++) wexp[j] = 32'h0;
        wexp[0]  = 32'h61626380;
        wexp[15] = 32'h00000018;
        for (int j = 16; j < 68; j++)
            wexp[j] = p1(wexp[j-16] ^ wexp[j-9] ^ rol(wexp[j-3], 15))
                      ^ rol(wexp[j-13], 7) ^ wexp[j-6];
        v_w = iv_w;
        for (int j = 0; j < 64; j++) begin
            apply(j < 16, rol((j < 16) ? 32'h79cc4519 : 32'h7a879d8a, j),
                  wexp[j], wexp[j] ^ wexp[j+4], v_w);
            #1 v_w = o0_w;
        end
        push_exp(dig_w, 1'b1);
        check_out("digest", v_w ^ iv_w, vo0);

        // Registered build: reset wins over a simultaneous valid.
        @(negedge clk);
        apply(1'b1, 32'h79cc4519, 32'h61626380, 32'h61626380, iv_w);
        rst = 1'b1; vld1_i = 1'b1;
        push_exp(iv_w, 1'b0);
        @(posedge clk); #1 check_out("reg_rst", o1_w, vo1);

        // One-cycle latency on the "abc" j=0 round.
        rst = 1'b0;
        push_exp(abc_w, 1'b1);
        @(posedge clk); #1 check_out("reg_abc", o1_w, vo1);

        // Valid low: words hold, valid drops, despite new inputs.
        vld1_i = 1'b0;
        apply(1'b0, 32'h0, 32'h0, 32'h0, fsel_w);
        push_exp(abc_w, 1'b0);
        @(posedge clk); #1 check_out("reg_hold", o1_w, vo1);

        // New result loads after the hold.
        vld1_i = 1'b1;
        push_exp({32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h0, 32'hffffffff,
                  32'hffffffff, 32'hffffffff}, 1'b1);
        @(posedge clk); #1 check_out("reg_fsel", o1_w, vo1);

        // Reset mid-stream discards the pending result.
        rst = 1'b1;
        apply(1'b1, 32'h0, 32'h1, 32'h1, wrap_w);
        push_exp(iv_w, 1'b0);
        @(posedge clk); #1 check_out("reg_midrst", o1_w, vo1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
